// File: rtl/axi4lite_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi4lite_rr_arbiter
//
// Shares one downstream AXI4-Lite slave between NUM_REQ upstream masters.
// The write path (AW/W/B) and the read path (AR/R) are arbitrated
// independently, each with its own round-robin pointer. Each path carries at
// most one outstanding transaction, and a read may overlap a write. Nothing
// is buffered. Channels are muxed combinationally to and from the current
// grantee, so ready/valid pass straight through the arbiter.
//
// Parameters
//   DATAWIDTH  data bus width (strobe width is DATAWIDTH/8)
//   ADDRWIDTH  address bus width
//   NUM_REQ    number of upstream requesters (>= 2)
//
// Ports (all s_* buses are packed, with requester i in slice i)
//   aclk, areset                      clock, synchronous active-high reset
//   s_aw{addr,prot,valid} / s_awready upstream write-address channels
//   s_w{data,strb,valid}  / s_wready  upstream write-data channels
//   s_b{resp,valid}       / s_bready  upstream write-response channels
//   s_ar{addr,prot,valid} / s_arready upstream read-address channels
//   s_r{data,resp,valid}  / s_rready  upstream read-data channels
//   m_aw*, m_w*, m_b*, m_ar*, m_r*    single downstream AXI4-Lite master port
// -----------------------------------------------------------------------------
module axi4lite_rr_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32,
  parameter int NUM_REQ   = 2
) (
  input  logic                                aclk,
  input  logic                                areset,

  // Upstream write address
  input  logic [NUM_REQ*ADDRWIDTH-1:0]        s_awaddr,
  input  logic [NUM_REQ*3-1:0]                s_awprot,
  input  logic [NUM_REQ-1:0]                  s_awvalid,
  output logic [NUM_REQ-1:0]                  s_awready,
  // Upstream write data
  input  logic [NUM_REQ*DATAWIDTH-1:0]        s_wdata,
  input  logic [NUM_REQ*(DATAWIDTH/8)-1:0]    s_wstrb,
  input  logic [NUM_REQ-1:0]                  s_wvalid,
  output logic [NUM_REQ-1:0]                  s_wready,
  // Upstream write response
  output logic [NUM_REQ*2-1:0]                s_bresp,
  output logic [NUM_REQ-1:0]                  s_bvalid,
  input  logic [NUM_REQ-1:0]                  s_bready,
  // Upstream read address
  input  logic [NUM_REQ*ADDRWIDTH-1:0]        s_araddr,
  input  logic [NUM_REQ*3-1:0]                s_arprot,
  input  logic [NUM_REQ-1:0]                  s_arvalid,
  output logic [NUM_REQ-1:0]                  s_arready,
  // Upstream read data
  output logic [NUM_REQ*DATAWIDTH-1:0]        s_rdata,
  output logic [NUM_REQ*2-1:0]                s_rresp,
  output logic [NUM_REQ-1:0]                  s_rvalid,
  input  logic [NUM_REQ-1:0]                  s_rready,

  // Downstream write address
  output logic [ADDRWIDTH-1:0]                m_awaddr,
  output logic [2:0]                          m_awprot,
  output logic                                m_awvalid,
  input  logic                                m_awready,
  // Downstream write data
  output logic [DATAWIDTH-1:0]                m_wdata,
  output logic [DATAWIDTH/8-1:0]              m_wstrb,
  output logic                                m_wvalid,
  input  logic                                m_wready,
  // Downstream write response
  input  logic [1:0]                          m_bresp,
  input  logic                                m_bvalid,
  output logic                                m_bready,
  // Downstream read address
  output logic [ADDRWIDTH-1:0]                m_araddr,
  output logic [2:0]                          m_arprot,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  // Downstream read data
  input  logic [DATAWIDTH-1:0]                m_rdata,
  input  logic [1:0]                          m_rresp,
  input  logic                                m_rvalid,
  output logic                                m_rready
);

  localparam int STRBWIDTH = DATAWIDTH / 8;
  localparam int IW        = $clog2(NUM_REQ);

  typedef logic [IW-1:0] idx_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  // ---------------------------------------------------------------------------
  // Round-robin pick: the first requesting index strictly after 'last',
  // wrapping modulo NUM_REQ. Each candidate j is scored by its distance from
  // last+1, and the smallest distance wins. The result is only used when at
  // least one request is present.
  // ---------------------------------------------------------------------------
  function automatic idx_t rr_pick(input logic [NUM_REQ-1:0] req, input idx_t last);
    idx_t                pick;
    int                  best_d;
    int                  d;
    logic [NUM_REQ-1:0]  onehot;
    // NOTE: every local gets a value before any conditional use, so no path
    // leaves a stale value behind (no latch once this is inlined into logic).
    pick   = last;
    best_d = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      onehot = NUM_REQ'(1) << j;
      d      = (j - int'(last) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if ((|(req & onehot)) && (d < best_d)) begin
        best_d = d;
        pick   = idx_t'(j);
      end
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wr_state_t wr_state;
  idx_t      wr_gnt;
  idx_t      wr_last;
  logic      aw_done;
  logic      w_done;

  rd_state_t rd_state;
  idx_t      rd_gnt;
  idx_t      rd_last;

  // ---------------------------------------------------------------------------
  // Unpack the packed upstream buses so the grantee can be selected by index
  // ---------------------------------------------------------------------------
  logic [ADDRWIDTH-1:0] aw_addr_a [NUM_REQ];
  logic [2:0]           aw_prot_a [NUM_REQ];
  logic [DATAWIDTH-1:0] w_data_a  [NUM_REQ];
  logic [STRBWIDTH-1:0] w_strb_a  [NUM_REQ];
  logic [ADDRWIDTH-1:0] ar_addr_a [NUM_REQ];
  logic [2:0]           ar_prot_a [NUM_REQ];

  // Per-phase enables. The done flags stop a channel from being offered a
  // second time while its partner channel is still waiting.
  logic aw_active, w_active, b_active;
  logic ar_active, r_active;

  assign aw_active = (wr_state == W_ADDR) && !aw_done;
  assign w_active  = (wr_state == W_ADDR) && !w_done;
  assign b_active  = (wr_state == W_RESP);
  assign ar_active = (rd_state == R_ADDR);
  assign r_active  = (rd_state == R_DATA);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    logic wr_sel;
    logic rd_sel;

    assign aw_addr_a[g] = s_awaddr[g*ADDRWIDTH +: ADDRWIDTH];
    assign aw_prot_a[g] = s_awprot[g*3 +: 3];
    assign w_data_a[g]  = s_wdata[g*DATAWIDTH +: DATAWIDTH];
    assign w_strb_a[g]  = s_wstrb[g*STRBWIDTH +: STRBWIDTH];
    assign ar_addr_a[g] = s_araddr[g*ADDRWIDTH +: ADDRWIDTH];
    assign ar_prot_a[g] = s_arprot[g*3 +: 3];

    assign wr_sel = (wr_gnt == idx_t'(g));
    assign rd_sel = (rd_gnt == idx_t'(g));

    // Upstream returns: non-granted requesters see all zeros
    assign s_awready[g]             = aw_active && wr_sel && m_awready;
    assign s_wready[g]              = w_active  && wr_sel && m_wready;
    assign s_bvalid[g]              = b_active  && wr_sel && m_bvalid;
    assign s_bresp[g*2 +: 2]        = (b_active && wr_sel) ? m_bresp : 2'b00;
    assign s_arready[g]             = ar_active && rd_sel && m_arready;
    assign s_rvalid[g]              = r_active  && rd_sel && m_rvalid;
    assign s_rresp[g*2 +: 2]        = (r_active && rd_sel) ? m_rresp : 2'b00;
    assign s_rdata[g*DATAWIDTH +: DATAWIDTH] =
      (r_active && rd_sel) ? m_rdata : '0;
  end

  // ---------------------------------------------------------------------------
  // Downstream forward muxes
  // ---------------------------------------------------------------------------
  assign m_awvalid = aw_active && s_awvalid[wr_gnt];
  assign m_awaddr  = aw_active ? aw_addr_a[wr_gnt] : '0;
  assign m_awprot  = aw_active ? aw_prot_a[wr_gnt] : '0;

  assign m_wvalid  = w_active && s_wvalid[wr_gnt];
  assign m_wdata   = w_active ? w_data_a[wr_gnt] : '0;
  assign m_wstrb   = w_active ? w_strb_a[wr_gnt] : '0;

  assign m_bready  = b_active && s_bready[wr_gnt];

  assign m_arvalid = ar_active && s_arvalid[rd_gnt];
  assign m_araddr  = ar_active ? ar_addr_a[rd_gnt] : '0;
  assign m_arprot  = ar_active ? ar_prot_a[rd_gnt] : '0;

  assign m_rready  = r_active && s_rready[rd_gnt];

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_fin, w_fin;
  idx_t wr_win, rd_win;

  assign aw_hs  = m_awvalid && m_awready;
  assign w_hs   = m_wvalid  && m_wready;
  assign b_hs   = m_bvalid  && m_bready;
  assign ar_hs  = m_arvalid && m_arready;
  assign r_hs   = m_rvalid  && m_rready;

  // A channel is finished if it completed earlier or completes this cycle
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done  || w_hs;

  assign wr_win = rr_pick(s_awvalid, wr_last);
  assign rd_win = rr_pick(s_arvalid, rd_last);

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  // The pointer resets to NUM_REQ-1 so that requester 0 wins the first grant.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state <= W_IDLE;
      wr_gnt   <= '0;
      wr_last  <= idx_t'(NUM_REQ - 1);
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (|s_awvalid) begin
            wr_gnt   <= wr_win;
            wr_last  <= wr_win;
            wr_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (aw_fin && w_fin) begin
            wr_state <= W_RESP;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end else begin
            aw_done  <= aw_fin;
            w_done   <= w_fin;
          end
        end
        W_RESP: begin
          if (b_hs) begin
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state <= R_IDLE;
      rd_gnt   <= '0;
      rd_last  <= idx_t'(NUM_REQ - 1);
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (|s_arvalid) begin
            rd_gnt   <= rd_win;
            rd_last  <= rd_win;
            rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ar_hs) begin
            rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
